// File: rtl/avalon_bus_arbiter_if.sv
// Bus bundle for the two-host Avalon-MM arbiter: instruction host, data host and the
// shared memory agent. The slave view is the arbiter; the master view is everything
// around it (both hosts plus the agent).
interface avalon_bus_arbiter_if;
    // Instruction host (read-only)
    logic        ibus_read;
    logic [31:0] ibus_address;
    logic        ibus_waitrequest;
    logic        ibus_readdatavalid;
    logic [31:0] ibus_readdata;
    // Data host (read/write)
    logic        dbus_read;
    logic        dbus_write;
    logic [31:0] dbus_address;
    logic [3:0]  dbus_byteenable;
    logic [31:0] dbus_writedata;
    logic        dbus_waitrequest;
    logic        dbus_readdatavalid;
    logic [31:0] dbus_readdata;
    // Shared memory agent
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        mem_waitrequest;
    logic        mem_readdatavalid;
    logic [31:0] mem_readdata;

    modport slave (
        input  ibus_read, ibus_address,
        output ibus_waitrequest, ibus_readdatavalid, ibus_readdata,
        input  dbus_read, dbus_write, dbus_address, dbus_byteenable, dbus_writedata,
        output dbus_waitrequest, dbus_readdatavalid, dbus_readdata,
        output mem_read, mem_write, mem_address, mem_byteenable, mem_writedata,
        input  mem_waitrequest, mem_readdatavalid, mem_readdata
    );

    modport master (
        output ibus_read, ibus_address,
        input  ibus_waitrequest, ibus_readdatavalid, ibus_readdata,
        output dbus_read, dbus_write, dbus_address, dbus_byteenable, dbus_writedata,
        input  dbus_waitrequest, dbus_readdatavalid, dbus_readdata,
        input  mem_read, mem_write, mem_address, mem_byteenable, mem_writedata,
        output mem_waitrequest, mem_readdatavalid, mem_readdata
    );
endinterface

// File: rtl/avalon_bus_arbiter.sv
// Two-host Avalon-MM arbiter: instruction host (read-only) and data host (read/write)
// share one memory agent with a single transaction in flight. The owner's live command
// is forwarded while in CMD; read responses (or a forced zero on timeout) are routed
// back to the owner only.
module avalon_bus_arbiter #(
    parameter bit          DATA_PRIORITY = 1'b1,
    parameter int unsigned RESP_TIMEOUT  = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    avalon_bus_arbiter_if.slave  bus,
    output logic                 timeout_err_o
);
    localparam int unsigned      CntW   = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
    localparam logic [CntW-1:0]  CntMax = CntW'(RESP_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StCmd, StResp} state_e;
    typedef enum logic {OwnI = 1'b0, OwnD = 1'b1} owner_e;

    state_e          state_q;
    owner_e          owner_q;
    owner_e          last_owner_q;
    logic [CntW-1:0] cnt_q;
    logic            timeout_err_q;

    logic        req_i;
    logic        req_d;
    owner_e      grant;
    logic        own_read;
    logic        own_write;
    logic        resp_valid;
    logic [31:0] resp_data;

    // Arbitration among live requests; simultaneous requests use priority or alternation.
    always_comb begin
        req_i = bus.ibus_read;
        req_d = bus.dbus_read | bus.dbus_write;
        grant = OwnI;
        if (req_i && req_d) begin
            if (DATA_PRIORITY) begin
                grant = OwnD;
            end else begin
                grant = (last_owner_q == OwnD) ? OwnI : OwnD;
            end
        end else if (req_d) begin
            grant = OwnD;
        end
    end

    // Owner's live command; a data read+write together counts as a write.
    always_comb begin
        own_read  = 1'b0;
        own_write = 1'b0;
        if (owner_q == OwnD) begin
            own_write = bus.dbus_write;
            own_read  = bus.dbus_read & ~bus.dbus_write;
        end else begin
            own_read  = bus.ibus_read;
        end
    end

    // Response seen by the owner: agent data, or forced zero at the timeout limit.
    always_comb begin
        resp_valid = (state_q == StResp) && (bus.mem_readdatavalid || (cnt_q == CntMax));
        resp_data  = bus.mem_readdatavalid ? bus.mem_readdata : 32'h0000_0000;
    end

    // Main FSM: IDLE -> CMD -> (RESP for reads) -> IDLE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            owner_q       <= OwnD;
            last_owner_q  <= OwnD;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_i || req_d) begin
                        owner_q <= grant;
                        state_q <= StCmd;
                    end
                end
                StCmd: begin
                    if (!own_read && !own_write) begin
                        // Host withdrew its request mid-command: abandon it.
                        state_q <= StIdle;
                    end else if (!bus.mem_waitrequest) begin
                        last_owner_q <= owner_q;
                        if (own_write) begin
                            state_q <= StIdle;
                        end else begin
                            state_q <= StResp;
                            cnt_q   <= '0;
                        end
                    end
                end
                StResp: begin
                    if (bus.mem_readdatavalid) begin
                        state_q <= StIdle;
                    end else if (cnt_q == CntMax) begin
                        state_q       <= StIdle;
                        timeout_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Bus outputs: forward the owner's command in CMD, route the response in RESP.
    always_comb begin
        bus.mem_read           = 1'b0;
        bus.mem_write          = 1'b0;
        bus.mem_address        = 32'h0000_0000;
        bus.mem_byteenable     = 4'h0;
        bus.mem_writedata      = 32'h0000_0000;
        bus.ibus_waitrequest   = 1'b1;
        bus.dbus_waitrequest   = 1'b1;
        bus.ibus_readdatavalid = 1'b0;
        bus.dbus_readdatavalid = 1'b0;
        bus.ibus_readdata      = 32'h0000_0000;
        bus.dbus_readdata      = 32'h0000_0000;
        unique case (state_q)
            StCmd: begin
                bus.mem_read  = own_read;
                bus.mem_write = own_write;
                if (owner_q == OwnD) begin
                    bus.mem_address      = bus.dbus_address;
                    bus.mem_byteenable   = bus.dbus_byteenable;
                    bus.mem_writedata    = bus.dbus_writedata;
                    bus.dbus_waitrequest = bus.mem_waitrequest;
                end else begin
                    bus.mem_address      = bus.ibus_address;
                    bus.mem_byteenable   = 4'hF;
                    bus.ibus_waitrequest = bus.mem_waitrequest;
                end
            end
            StResp: begin
                if (resp_valid) begin
                    if (owner_q == OwnD) begin
                        bus.dbus_readdatavalid = 1'b1;
                        bus.dbus_readdata      = resp_data;
                    end else begin
                        bus.ibus_readdatavalid = 1'b1;
                        bus.ibus_readdata      = resp_data;
                    end
                end
            end
            default: ;
        endcase
    end

    assign timeout_err_o = timeout_err_q;
endmodule
